// File: rtl/rtu_gap_timer_dpram.sv
// rtu_gap_timer_dpram
//   Modbus RTU receive-side helper on one clock domain:
//   - inter-character gap timer that pulses rx_drop_frame once 1.5 character
//     times of silence follow a byte, and rx_new_frame after 3.5 character times
//   - true dual-port, read-first register RAM (port A handler, port B bus side)
// Ports:
//   clk_in, rst_n_in           clock, asynchronous active-low reset
//   rx_done, rx_state          UART byte-received pulse / byte-in-progress level
//   rx_drop_frame, rx_new_frame one-cycle gap pulses
//   ena, wea, addra, dia, doa  RAM port A
//   enb, web, addrb, dib, dob  RAM port B
module rtu_gap_timer_dpram #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115_200,
  parameter int A_WIDTH   = 8,
  parameter int D_WIDTH   = 16
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic               rx_done,
  input  logic               rx_state,
  output logic               rx_drop_frame,
  output logic               rx_new_frame,
  input  logic               ena,
  input  logic               wea,
  input  logic [A_WIDTH-1:0] addra,
  input  logic [D_WIDTH-1:0] dia,
  output logic [D_WIDTH-1:0] doa,
  input  logic               enb,
  input  logic               web,
  input  logic [A_WIDTH-1:0] addrb,
  input  logic [D_WIDTH-1:0] dib,
  output logic [D_WIDTH-1:0] dob
);

  // Above 19200 baud Modbus fixes the gaps at 750 us / 1750 us; below it they
  // scale with an 11-bit character. 64-bit math avoids overflow at elaboration.
  localparam longint T15_CYC = (BAUD_RATE > 19200)
                               ? (longint'(CLK_FREQ) * 750) / 1000000
                               : (longint'(CLK_FREQ) * 33) / (2 * longint'(BAUD_RATE));
  localparam longint T35_CYC = (BAUD_RATE > 19200)
                               ? (longint'(CLK_FREQ) * 1750) / 1000000
                               : (longint'(CLK_FREQ) * 77) / (2 * longint'(BAUD_RATE));
  localparam int CNT_W = $clog2(T35_CYC + 1);

  // The counter holds (cycles since rx_done) - 1, so the pulse fires on the
  // edge that is exactly T cycles after the rx_done edge.
  localparam logic [CNT_W-1:0] T15_LAST = CNT_W'(T15_CYC - 1);
  localparam logic [CNT_W-1:0] T35_LAST = CNT_W'(T35_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic {IDLE, COUNT} timer_state_t;

  timer_state_t state15, state15_next;
  timer_state_t state35, state35_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic drop_next, new_next;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state15       <= IDLE;
      state35       <= IDLE;
      cnt           <= '0;
      rx_drop_frame <= 1'b0;
      rx_new_frame  <= 1'b0;
    end else begin
      state15       <= state15_next;
      state35       <= state35_next;
      cnt           <= cnt_next;
      rx_drop_frame <= drop_next;
      rx_new_frame  <= new_next;
    end
  end

  // Both timers share one counter: they start together, a new byte stops both,
  // and the 3.5T timer is always still counting while the 1.5T one is.
  always_comb begin
    state15_next = state15;
    state35_next = state35;
    cnt_next     = cnt;
    drop_next    = 1'b0;
    new_next     = 1'b0;
    if (rx_done) begin
      state15_next = COUNT;
      state35_next = COUNT;
      cnt_next     = '0;
    end else begin
      if (state15 == COUNT) begin
        if (rx_state) begin
          state15_next = IDLE;
        end else if (cnt == T15_LAST) begin
          drop_next    = 1'b1;
          state15_next = IDLE;
        end
      end
      if (state35 == COUNT) begin
        if (rx_state) begin
          state35_next = IDLE;
        end else if (cnt == T35_LAST) begin
          new_next     = 1'b1;
          state35_next = IDLE;
        end else if (cnt != CNT_MAX) begin
          cnt_next = cnt + 1'b1;
        end
      end
    end
  end

  logic [D_WIDTH-1:0] mem [2**A_WIDTH];

  // Port B is written first so that port A wins a same-address collision.
  always_ff @(posedge clk_in) begin
    if (enb && web) mem[addrb] <= dib;
    if (ena && wea) mem[addra] <= dia;
  end

  // Reads sample the array before this edge's writes land, giving read-first
  // behaviour on both ports and old data for cross-port same-cycle reads.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      doa <= '0;
      dob <= '0;
    end else begin
      if (ena) doa <= mem[addra];
      if (enb) dob <= mem[addrb];
    end
  end

endmodule

// File: tb/tb_rtu_gap_timer_dpram.sv
// tb_rtu_gap_timer_dpram
//   Self-checking bench for rtu_gap_timer_dpram. A reduced clock frequency keeps
//   the gap timeouts short (T15 = 150, T35 = 350 cycles at 115200 baud).
module tb_rtu_gap_timer_dpram;

  localparam int CLK_FREQ = 200_000;
  localparam int BAUD     = 115_200;
  localparam int AW       = 8;
  localparam int DW       = 16;
  localparam int T15 = (BAUD > 19200) ? (CLK_FREQ / 1000) * 750 / 1000
                                      : CLK_FREQ * 33 / (2 * BAUD);
  localparam int T35 = (BAUD > 19200) ? (CLK_FREQ / 1000) * 1750 / 1000
                                      : CLK_FREQ * 77 / (2 * BAUD);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx_done = 1'b0;
  logic rx_state = 1'b0;
  logic rx_drop_frame, rx_new_frame;
  logic ena = 1'b0, wea = 1'b0, enb = 1'b0, web = 1'b0;
  logic [AW-1:0] addra = '0, addrb = '0;
  logic [DW-1:0] dia = '0, dib = '0;
  logic [DW-1:0] doa, dob;

  rtu_gap_timer_dpram #(
    .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .A_WIDTH(AW), .D_WIDTH(DW)
  ) dut (
    .clk_in(clk), .rst_n_in(rst_n),
    .rx_done(rx_done), .rx_state(rx_state),
    .rx_drop_frame(rx_drop_frame), .rx_new_frame(rx_new_frame),
    .ena(ena), .wea(wea), .addra(addra), .dia(dia), .doa(doa),
    .enb(enb), .web(web), .addrb(addrb), .dib(dib), .dob(dob)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Timer model: remembers when the last byte finished and which gap
  // pulses are still owed for it.
  longint cyc = 0;
  longint start_cyc = 0;
  bit arm15 = 0, arm35 = 0;
  logic exp_drop = 0, exp_new = 0;
  int drop_cnt = 0, new_cnt = 0;

  // RAM model with a record of which words hold a known value.
  logic [DW-1:0] mem_m [2**AW];
  bit known [2**AW];
  logic [DW-1:0] exp_doa = '0, exp_dob = '0;
  bit doa_known = 1, dob_known = 1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    exp_drop = 0;
    exp_new  = 0;
    if (!rst_n) begin
      arm15 = 0;
      arm35 = 0;
      exp_doa = '0;
      exp_dob = '0;
      doa_known = 1;
      dob_known = 1;
    end else begin
      if (rx_done) begin
        start_cyc = cyc;
        arm15 = 1;
        arm35 = 1;
      end else if (rx_state) begin
        arm15 = 0;
        arm35 = 0;
      end else begin
        if (arm15 && (cyc - start_cyc == T15)) begin exp_drop = 1; arm15 = 0; end
        if (arm35 && (cyc - start_cyc == T35)) begin exp_new = 1; arm35 = 0; end
      end
      if (ena) begin exp_doa = mem_m[addra]; doa_known = known[addra]; end
      if (enb) begin exp_dob = mem_m[addrb]; dob_known = known[addrb]; end
      if (enb && web) begin mem_m[addrb] = dib; known[addrb] = 1; end
      if (ena && wea) begin mem_m[addra] = dia; known[addra] = 1; end
    end
    #1;
    drop_cnt += int'(rx_drop_frame);
    new_cnt  += int'(rx_new_frame);
    checkOutput("drop", rx_drop_frame, exp_drop);
    checkOutput("new", rx_new_frame, exp_new);
    if (doa_known) checkOutput("doa", doa, exp_doa);
    if (dob_known) checkOutput("dob", dob, exp_dob);
  endtask

  task automatic applyStimulus(input logic done, input logic st);
    rx_done  = done;
    rx_state = st;
    tick();
  endtask

  task automatic ramOp(input logic ea, input logic wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                       input logic eb, input logic wb, input logic [AW-1:0] ab, input logic [DW-1:0] db);
    ena = ea; wea = wa; addra = aa; dia = da;
    enb = eb; web = wb; addrb = ab; dib = db;
    applyStimulus(1'b0, 1'b0);
  endtask

  task automatic ramIdle();
    ena = 0; wea = 0; enb = 0; web = 0;
  endtask

  task automatic ramRandom();
    ena = 1'($urandom); wea = 1'($urandom);
    addra = AW'($urandom_range(0, 15)); dia = DW'($urandom);
    enb = 1'($urandom); web = 1'($urandom);
    addrb = AW'($urandom_range(0, 15)); dib = DW'($urandom);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 2**AW; i++) begin mem_m[i] = '0; known[i] = 0; end

    // Reset state
    repeat (3) tick();
    checkOutput("rst_drop", rx_drop_frame, 0);
    checkOutput("rst_doa", doa, 0);
    rst_n = 1'b1;

    // Single byte, silence afterwards
    drop_cnt = 0; new_cnt = 0;
    applyStimulus(1'b1, 1'b0);
    idle(T35 + 30);
    checkOutput("single_drop_cnt", drop_cnt, 1);
    checkOutput("single_new_cnt", new_cnt, 1);

    // Eight-byte frame with short inter-byte spacing
    drop_cnt = 0; new_cnt = 0;
    for (int b = 0; b < 8; b++) begin
      for (int i = 0; i < 15; i++) applyStimulus(1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0);
      idle(2);
    end
    idle(T35 + 30);
    checkOutput("frame_drop_cnt", drop_cnt, 1);
    checkOutput("frame_new_cnt", new_cnt, 1);

    // New byte starts before 1.5T: no pulses, then a fresh full count
    drop_cnt = 0; new_cnt = 0;
    applyStimulus(1'b1, 1'b0);
    idle(T15 - 30);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1);
    idle(T35 + 30);
    checkOutput("abort_drop_cnt", drop_cnt, 0);
    checkOutput("abort_new_cnt", new_cnt, 0);
    applyStimulus(1'b1, 1'b0);
    idle(T35 + 30);
    checkOutput("restart_new_cnt", new_cnt, 1);

    // rx_done together with rx_state: restart wins
    drop_cnt = 0; new_cnt = 0;
    applyStimulus(1'b1, 1'b0);
    idle(40);
    applyStimulus(1'b1, 1'b1);
    idle(T35 + 30);
    checkOutput("both_drop_cnt", drop_cnt, 1);
    checkOutput("both_new_cnt", new_cnt, 1);

    // RAM: write then cross-port read, read-first on the writing port
    ramOp(0, 0, 8'h00, 16'h0, 1, 1, 8'h01, 16'h1234);
    ramOp(1, 1, 8'h01, 16'h0451, 0, 0, 8'h00, 16'h0);
    checkOutput("a_read_first", doa, 16'h1234);
    ramOp(1, 1, 8'h01, 16'h0777, 1, 0, 8'h01, 16'h0);
    checkOutput("b_after_a_write", dob, 16'h0451);
    checkOutput("a_read_first2", doa, 16'h0451);
    ramOp(0, 0, 8'h00, 16'h0, 1, 0, 8'h01, 16'h0);
    checkOutput("b_sees_new", dob, 16'h0777);

    // Collision: port A wins
    ramOp(1, 1, 8'h05, 16'h1111, 1, 1, 8'h05, 16'h2222);
    ramOp(1, 0, 8'h05, 16'h0, 1, 0, 8'h05, 16'h0);
    checkOutput("collide_a", doa, 16'h1111);
    checkOutput("collide_b", dob, 16'h1111);

    // Disabled port holds its output and does not write
    ramOp(0, 1, 8'h05, 16'hBEEF, 0, 1, 8'h05, 16'hCAFE);
    checkOutput("hold_a", doa, 16'h1111);
    ramOp(0, 0, 8'h00, 16'h0, 1, 0, 8'h05, 16'h0);
    checkOutput("no_write_dis", dob, 16'h1111);
    ramIdle();

    // Reset mid-count, between the two timeouts
    drop_cnt = 0; new_cnt = 0;
    applyStimulus(1'b1, 1'b0);
    idle(T15 + 50);
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_new", rx_new_frame, 0);
    checkOutput("async_rst_doa", doa, 0);
    checkOutput("async_rst_dob", dob, 0);
    idle(10);
    rst_n = 1'b1;
    idle(T35);
    checkOutput("rst_abort_drop_cnt", drop_cnt, 1);
    checkOutput("rst_abort_new_cnt", new_cnt, 0);

    // Randomized traffic on both the timer and the RAM
    for (int it = 0; it < 25; it++) begin
      int gap = $urandom_range(1, T35 + 70);
      int burst = $urandom_range(0, 20);
      for (int i = 0; i < gap; i++) begin ramRandom(); applyStimulus(1'b0, 1'b0); end
      for (int i = 0; i < burst; i++) begin ramRandom(); applyStimulus(1'b0, 1'b1); end
      ramRandom();
      applyStimulus(1'b1, 1'($urandom));
    end
    ramIdle();
    idle(T35 + 10);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
